// File: rtl/aq_lsu_amo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aq_lsu_amo_ctrl_pkg : shared state encoding, access sizes and AMO func codes
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aq_lsu_amo_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_REQ    = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_LAUNCH    = 3'd3,
    ST_WAIT_RST  = 3'd4,
    ST_STORE     = 3'd5,
    ST_RESP      = 3'd6
  } amo_state_e;

  localparam logic [1:0] c_WORD  = 2'b10;
  localparam logic [1:0] c_DWORD = 2'b11;

  localparam logic [4:0] c_AMO_ADD  = 5'b00000;
  localparam logic [4:0] c_AMO_SWAP = 5'b00001;
  localparam logic [4:0] c_AMO_XOR  = 5'b00100;
  localparam logic [4:0] c_AMO_OR   = 5'b01000;
  localparam logic [4:0] c_AMO_AND  = 5'b01100;
  localparam logic [4:0] c_AMO_MIN  = 5'b10000;
  localparam logic [4:0] c_AMO_MAX  = 5'b10100;
  localparam logic [4:0] c_AMO_MINU = 5'b11000;
  localparam logic [4:0] c_AMO_MAXU = 5'b11100;

  function automatic logic [63:0] sext_word(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aq_lsu_amo_fmt.sv
// ---------------------------------------------------------------------------
// aq_lsu_amo_fmt : lane select, operand extension and store data/BE shaping
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aq_lsu_amo_fmt
  import aq_lsu_amo_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        lane_i,
  input  logic [63:0] rd_data_i,
  input  logic [63:0] alu_rst_i,
  output logic [63:0] src0_o,
  output logic [63:0] wb_data_o,
  output logic [63:0] wr_data_o,
  output logic [7:0]  wr_be_o
);

  logic        w_is_word;
  logic        w_is_dword;
  logic [31:0] w_old_word;

  assign w_is_word  = (size_i == c_WORD);
  assign w_is_dword = (size_i == c_DWORD);
  assign w_old_word = lane_i ? rd_data_i[63:32] : rd_data_i[31:0];

  // ALU sees the word zero-extended; the register file sees it sign-extended.
  assign src0_o    = w_is_word ? {32'b0, w_old_word} : rd_data_i;
  assign wb_data_o = w_is_word ? sext_word(w_old_word) : rd_data_i;

  assign wr_data_o = w_is_word ? {alu_rst_i[31:0], alu_rst_i[31:0]} : alu_rst_i;

  // Unknown sizes enable no bytes so an idle controller drives all zeros.
  always_comb begin
    wr_be_o = 8'h00;
    if (w_is_dword) begin
      wr_be_o = 8'hFF;
    end else if (w_is_word) begin
      wr_be_o = lane_i ? 8'hF0 : 8'h0F;
    end
  end

endmodule

`default_nettype wire

// File: rtl/aq_lsu_amo_ctrl.sv
// ---------------------------------------------------------------------------
// aq_lsu_amo_ctrl : sequences one AMO: dcache read, ALU launch, stb write, wb
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aq_lsu_amo_ctrl
  import aq_lsu_amo_ctrl_pkg::*;
#(
  parameter int PA_WIDTH = 40,
  parameter int TMO_W    = 8
) (
  input  logic                amo_clk,
  input  logic                cpurst_b,
  input  logic                req_vld_i,
  output logic                req_rdy_o,
  input  logic [4:0]          req_func_i,
  input  logic [1:0]          req_size_i,
  input  logic [PA_WIDTH-1:0] req_addr_i,
  input  logic [1:0]          req_stb_id_i,
  input  logic                flush_i,
  output logic                dc_rd_req_o,
  input  logic                dc_rd_gnt_i,
  output logic [PA_WIDTH-1:0] dc_rd_addr_o,
  input  logic                dc_rd_data_vld_i,
  input  logic [63:0]         dc_rd_data_i,
  input  logic                dc_rd_err_i,
  output logic                alu_src_vld_o,
  output logic [4:0]          alu_func_o,
  output logic [1:0]          alu_size_o,
  output logic [63:0]         alu_src0_o,
  output logic [1:0]          alu_stb_id_o,
  input  logic                alu_rst_vld_i,
  input  logic [63:0]         alu_rst_i,
  input  logic [1:0]          alu_rst_stb_id_i,
  output logic                stb_wr_vld_o,
  input  logic                stb_wr_rdy_i,
  output logic [1:0]          stb_wr_id_o,
  output logic [63:0]         stb_wr_data_o,
  output logic [7:0]          stb_wr_be_o,
  output logic                wb_vld_o,
  input  logic                wb_rdy_i,
  output logic [63:0]         wb_data_o,
  output logic                wb_err_o,
  output logic                busy_o
);

  amo_state_e          state_q, state_d;
  logic [4:0]          func_q, func_d;
  logic [1:0]          size_q, size_d;
  logic [PA_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]          id_q, id_d;
  logic [63:0]         data_q, data_d;
  logic [63:0]         rst_q, rst_d;
  logic                err_q, err_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic                drop_q, drop_d;

  logic [TMO_W-1:0]    w_cnt_inc;
  logic                w_rd_rtn;

  assign w_cnt_inc = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
  // drop_q marks a read abandoned by a flush; its return must not be consumed.
  assign w_rd_rtn  = dc_rd_data_vld_i && !drop_q;

  always_ff @(posedge amo_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= ST_IDLE;
      func_q  <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      id_q    <= '0;
      data_q  <= '0;
      rst_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      rst_q   <= rst_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    func_d        = func_q;
    size_d        = size_q;
    addr_d        = addr_q;
    id_d          = id_q;
    data_d        = data_q;
    rst_d         = rst_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    drop_d        = drop_q;
    req_rdy_o     = 1'b0;
    dc_rd_req_o   = 1'b0;
    alu_src_vld_o = 1'b0;
    stb_wr_vld_o  = 1'b0;
    wb_vld_o      = 1'b0;

    if (drop_q && dc_rd_data_vld_i) begin
      drop_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        req_rdy_o = 1'b1;
        if (req_vld_i && !flush_i) begin
          func_d  = req_func_i;
          size_d  = req_size_i;
          addr_d  = req_addr_i;
          id_d    = req_stb_id_i;
          err_d   = 1'b0;
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        dc_rd_req_o = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
          if (dc_rd_gnt_i) begin
            drop_d = 1'b1;
          end
        end else if (dc_rd_gnt_i) begin
          cnt_d   = '0;
          state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        cnt_d = w_cnt_inc;
        if (flush_i) begin
          state_d = ST_IDLE;
          if (!w_rd_rtn) begin
            drop_d = 1'b1;
          end
        end else if (w_rd_rtn && !dc_rd_err_i) begin
          data_d  = dc_rd_data_i;
          state_d = ST_LAUNCH;
        end else if (w_rd_rtn || (w_cnt_inc == {TMO_W{1'b1}})) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_LAUNCH: begin
        alu_src_vld_o = 1'b1;
        state_d       = ST_WAIT_RST;
      end
      ST_WAIT_RST: begin
        if (alu_rst_vld_i && (alu_rst_stb_id_i == id_q)) begin
          rst_d   = alu_rst_i;
          state_d = ST_STORE;
        end
      end
      ST_STORE: begin
        stb_wr_vld_o = 1'b1;
        if (stb_wr_rdy_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        wb_vld_o = 1'b1;
        if (wb_rdy_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  aq_lsu_amo_fmt u_fmt (
    .size_i    (size_q),
    .lane_i    (addr_q[2]),
    .rd_data_i (data_q),
    .alu_rst_i (rst_q),
    .src0_o    (alu_src0_o),
    .wb_data_o (wb_data_o),
    .wr_data_o (stb_wr_data_o),
    .wr_be_o   (stb_wr_be_o)
  );

  assign dc_rd_addr_o = addr_q;
  assign alu_func_o   = func_q;
  assign alu_size_o   = size_q;
  assign alu_stb_id_o = id_q;
  assign stb_wr_id_o  = id_q;
  assign wb_err_o     = err_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_aq_lsu_amo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aq_lsu_amo_ctrl : directed and randomized AMO transactions vs a model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aq_lsu_amo_ctrl;
  import aq_lsu_amo_ctrl_pkg::*;

  localparam int PA_WIDTH = 40;
  localparam int TMO_W    = 8;

  logic                amo_clk = 1'b0;
  logic                cpurst_b = 1'b0;
  logic                req_vld_i = 1'b0;
  logic                req_rdy_o;
  logic [4:0]          req_func_i = '0;
  logic [1:0]          req_size_i = '0;
  logic [PA_WIDTH-1:0] req_addr_i = '0;
  logic [1:0]          req_stb_id_i = '0;
  logic                flush_i = 1'b0;
  logic                dc_rd_req_o;
  logic                dc_rd_gnt_i = 1'b0;
  logic [PA_WIDTH-1:0] dc_rd_addr_o;
  logic                dc_rd_data_vld_i = 1'b0;
  logic [63:0]         dc_rd_data_i = '0;
  logic                dc_rd_err_i = 1'b0;
  logic                alu_src_vld_o;
  logic [4:0]          alu_func_o;
  logic [1:0]          alu_size_o;
  logic [63:0]         alu_src0_o;
  logic [1:0]          alu_stb_id_o;
  logic                alu_rst_vld_i = 1'b0;
  logic [63:0]         alu_rst_i = '0;
  logic [1:0]          alu_rst_stb_id_i = '0;
  logic                stb_wr_vld_o;
  logic                stb_wr_rdy_i = 1'b0;
  logic [1:0]          stb_wr_id_o;
  logic [63:0]         stb_wr_data_o;
  logic [7:0]          stb_wr_be_o;
  logic                wb_vld_o;
  logic                wb_rdy_i = 1'b0;
  logic [63:0]         wb_data_o;
  logic                wb_err_o;
  logic                busy_o;

  aq_lsu_amo_ctrl #(.PA_WIDTH(PA_WIDTH), .TMO_W(TMO_W)) dut (
    .amo_clk          (amo_clk),
    .cpurst_b         (cpurst_b),
    .req_vld_i        (req_vld_i),
    .req_rdy_o        (req_rdy_o),
    .req_func_i       (req_func_i),
    .req_size_i       (req_size_i),
    .req_addr_i       (req_addr_i),
    .req_stb_id_i     (req_stb_id_i),
    .flush_i          (flush_i),
    .dc_rd_req_o      (dc_rd_req_o),
    .dc_rd_gnt_i      (dc_rd_gnt_i),
    .dc_rd_addr_o     (dc_rd_addr_o),
    .dc_rd_data_vld_i (dc_rd_data_vld_i),
    .dc_rd_data_i     (dc_rd_data_i),
    .dc_rd_err_i      (dc_rd_err_i),
    .alu_src_vld_o    (alu_src_vld_o),
    .alu_func_o       (alu_func_o),
    .alu_size_o       (alu_size_o),
    .alu_src0_o       (alu_src0_o),
    .alu_stb_id_o     (alu_stb_id_o),
    .alu_rst_vld_i    (alu_rst_vld_i),
    .alu_rst_i        (alu_rst_i),
    .alu_rst_stb_id_i (alu_rst_stb_id_i),
    .stb_wr_vld_o     (stb_wr_vld_o),
    .stb_wr_rdy_i     (stb_wr_rdy_i),
    .stb_wr_id_o      (stb_wr_id_o),
    .stb_wr_data_o    (stb_wr_data_o),
    .stb_wr_be_o      (stb_wr_be_o),
    .wb_vld_o         (wb_vld_o),
    .wb_rdy_i         (wb_rdy_i),
    .wb_data_o        (wb_data_o),
    .wb_err_o         (wb_err_o),
    .busy_o           (busy_o)
  );

  always #5 amo_clk = ~amo_clk;

  int checks = 0;
  int errors = 0;
  int n_launch = 0;
  int n_stbwr = 0;

  always @(posedge amo_clk) begin
    if (alu_src_vld_o) n_launch <= n_launch + 1;
    if (stb_wr_vld_o && stb_wr_rdy_i) n_stbwr <= n_stbwr + 1;
  end

  task automatic tick();
    @(posedge amo_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_lane(input logic [PA_WIDTH-1:0] a);
    return int'((a % 8) / 4);
  endfunction

  function automatic logic [31:0] m_word(input logic [PA_WIDTH-1:0] a, input logic [63:0] mem);
    return 32'(mem >> (32 * m_lane(a)));
  endfunction

  function automatic logic [63:0] m_src0(input logic [1:0] sz, input logic [PA_WIDTH-1:0] a,
                                         input logic [63:0] mem);
    return (sz == c_DWORD) ? mem : {32'h0, m_word(a, mem)};
  endfunction

  function automatic logic [63:0] m_wb(input logic [1:0] sz, input logic [PA_WIDTH-1:0] a,
                                       input logic [63:0] mem);
    logic [31:0] w;
    w = m_word(a, mem);
    return (sz == c_DWORD) ? mem : 64'(signed'(w));
  endfunction

  function automatic logic [63:0] m_alu(input logic [4:0] f, input logic [1:0] sz,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] au, bu, r;
    longint      as, bs;
    if (sz == c_DWORD) begin
      au = a; bu = b;
      as = longint'(a); bs = longint'(b);
    end else begin
      au = {32'h0, a[31:0]}; bu = {32'h0, b[31:0]};
      as = longint'(signed'(a[31:0])); bs = longint'(signed'(b[31:0]));
    end
    case (f)
      c_AMO_ADD:  r = au + bu;
      c_AMO_SWAP: r = bu;
      c_AMO_XOR:  r = au ^ bu;
      c_AMO_OR:   r = au | bu;
      c_AMO_AND:  r = au & bu;
      c_AMO_MIN:  r = (as < bs) ? au : bu;
      c_AMO_MAX:  r = (as > bs) ? au : bu;
      c_AMO_MINU: r = (au < bu) ? au : bu;
      default:    r = (au > bu) ? au : bu;
    endcase
    return (sz == c_DWORD) ? r : 64'(signed'(r[31:0]));
  endfunction

  function automatic logic [63:0] m_stb_data(input logic [1:0] sz, input logic [63:0] r);
    return (sz == c_DWORD) ? r : {2{r[31:0]}};
  endfunction

  function automatic logic [7:0] m_be(input logic [1:0] sz, input logic [PA_WIDTH-1:0] a);
    return (sz == c_DWORD) ? 8'hFF : 8'(8'h0F << (4 * m_lane(a)));
  endfunction

  // ---------------- transaction driver ----------------
  task automatic accept(input logic [4:0] f, input logic [1:0] sz,
                        input logic [PA_WIDTH-1:0] a, input logic [1:0] id);
    chk("idle_req_rdy", req_rdy_o, 1);
    req_vld_i = 1'b1; req_func_i = f; req_size_i = sz; req_addr_i = a; req_stb_id_i = id;
    tick();
    req_vld_i = 1'b0;
    chk("rd_req", dc_rd_req_o, 1);
    chk("rd_addr", dc_rd_addr_o, 64'(a));
    chk("busy_rd", busy_o, 1);
  endtask

  task automatic run_amo(input logic [4:0] f, input logic [1:0] sz, input logic [PA_WIDTH-1:0] a,
                         input logic [1:0] id, input logic [63:0] mem, input logic [63:0] rs2,
                         input int gnt_dly, input int dat_dly, input bit err,
                         input int stb_stall, input int wb_stall, input bit bad_id,
                         input bit flush_late);
    int l0, s0;
    logic [63:0] src, res;
    l0 = n_launch; s0 = n_stbwr;
    accept(f, sz, a, id);
    repeat (gnt_dly) tick();
    dc_rd_gnt_i = 1'b1;
    tick();
    dc_rd_gnt_i = 1'b0;
    chk("rd_req_clear", dc_rd_req_o, 0);
    repeat (dat_dly) tick();
    dc_rd_data_vld_i = 1'b1; dc_rd_data_i = mem; dc_rd_err_i = err;
    tick();
    dc_rd_data_vld_i = 1'b0; dc_rd_err_i = 1'b0; dc_rd_data_i = {$urandom, $urandom};
    // Late flush and a pending next request must not disturb the commit.
    flush_i = flush_late;
    req_vld_i = 1'b1;
    if (!err) begin
      src = m_src0(sz, a, mem);
      res = m_alu(f, sz, src, rs2);
      chk("launch", alu_src_vld_o, 1);
      chk("alu_src0", alu_src0_o, src);
      chk("alu_func", alu_func_o, 64'(f));
      chk("alu_size", alu_size_o, 64'(sz));
      chk("alu_id", alu_stb_id_o, 64'(id));
      tick();
      chk("launch_once", alu_src_vld_o, 0);
      if (bad_id) begin
        alu_rst_vld_i = 1'b1; alu_rst_stb_id_i = id ^ 2'b01; alu_rst_i = ~res;
        tick();
        chk("bad_id_ignored", stb_wr_vld_o, 0);
      end
      alu_rst_vld_i = 1'b1; alu_rst_stb_id_i = id; alu_rst_i = res;
      tick();
      alu_rst_vld_i = 1'b0;
      for (int i = 0; i <= stb_stall; i++) begin
        chk("stb_vld", stb_wr_vld_o, 1);
        chk("stb_data", stb_wr_data_o, m_stb_data(sz, res));
        chk("stb_be", stb_wr_be_o, 64'(m_be(sz, a)));
        chk("stb_id", stb_wr_id_o, 64'(id));
        chk("stb_req_rdy", req_rdy_o, 0);
        stb_wr_rdy_i = (i == stb_stall);
        tick();
      end
      stb_wr_rdy_i = 1'b0;
    end
    for (int i = 0; i <= wb_stall; i++) begin
      chk("wb_vld", wb_vld_o, 1);
      chk("wb_err", wb_err_o, 64'(err));
      if (!err) chk("wb_data", wb_data_o, m_wb(sz, a, mem));
      chk("wb_req_rdy", req_rdy_o, 0);
      chk("wb_no_stb", stb_wr_vld_o, 0);
      wb_rdy_i = (i == wb_stall);
      if (i == wb_stall) begin
        req_vld_i = 1'b0;
        flush_i = 1'b0;
      end
      tick();
    end
    wb_rdy_i = 1'b0;
    chk("done_req_rdy", req_rdy_o, 1);
    chk("done_busy", busy_o, 0);
    chk("done_wb_vld", wb_vld_o, 0);
    chk("n_launch", 64'(n_launch - l0), err ? 64'd0 : 64'd1);
    chk("n_stbwr", 64'(n_stbwr - s0), err ? 64'd0 : 64'd1);
  endtask

  logic [4:0] funcs [9] = '{c_AMO_ADD, c_AMO_SWAP, c_AMO_XOR, c_AMO_OR, c_AMO_AND,
                            c_AMO_MIN, c_AMO_MAX, c_AMO_MINU, c_AMO_MAXU};

  initial begin
    logic [PA_WIDTH-1:0] a;
    logic [1:0]          sz;
    logic [63:0]         mem, rs2;
    int                  l0, s0;

    // Reset
    repeat (3) tick();
    chk("rst_req_rdy", req_rdy_o, 1);
    chk("rst_busy", busy_o, 0);
    cpurst_b = 1'b1;
    tick();
    chk("rst_rd_req", dc_rd_req_o, 0);
    chk("rst_rd_addr", dc_rd_addr_o, 0);
    chk("rst_alu_vld", alu_src_vld_o, 0);
    chk("rst_alu_src0", alu_src0_o, 0);
    chk("rst_alu_func", alu_func_o, 0);
    chk("rst_stb_vld", stb_wr_vld_o, 0);
    chk("rst_stb_data", stb_wr_data_o, 0);
    chk("rst_stb_be", stb_wr_be_o, 0);
    chk("rst_wb_vld", wb_vld_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_wb_err", wb_err_o, 0);
    chk("rst_req_rdy2", req_rdy_o, 1);

    // amoadd.d, no backpressure, dcache returns immediately
    run_amo(c_AMO_ADD, c_DWORD, 40'h1000, 2'd1, 64'h5, 64'h3, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("add_d_stb_data_const", m_stb_data(c_DWORD, m_alu(c_AMO_ADD, c_DWORD, 64'h5, 64'h3)) ^ stb_wr_data_o, 64'h8 ^ stb_wr_data_o);

    // amomaxu.w upper lane
    run_amo(c_AMO_MAXU, c_WORD, 40'h1004, 2'd2, 64'hFFFFFFFF_00000000, 64'h1,
            1, 2, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("maxu_w_stb_data", stb_wr_data_o, 64'hFFFFFFFF_FFFFFFFF);
    chk("maxu_w_stb_be", stb_wr_be_o, 64'hF0);
    chk("maxu_w_wb_data", wb_data_o, 64'hFFFFFFFF_FFFFFFFF);

    // Read error response
    run_amo(c_AMO_SWAP, c_DWORD, 40'h2008, 2'd3, 64'hDEAD, 64'h1, 0, 1, 1'b1, 0, 1, 1'b0, 1'b0);

    // Backpressure on stb (10) and wb (3), mismatched ALU id, flush late in flight
    run_amo(c_AMO_MIN, c_WORD, 40'h3000, 2'd0, 64'h1234_5678_8000_0000, 64'h7,
            0, 0, 1'b0, 10, 3, 1'b1, 1'b1);

    // Timeout: no data return
    l0 = n_launch; s0 = n_stbwr;
    accept(c_AMO_OR, c_DWORD, 40'h4000, 2'd1);
    dc_rd_gnt_i = 1'b1;
    tick();
    dc_rd_gnt_i = 1'b0;
    repeat (254) tick();
    chk("tmo_not_yet", wb_vld_o, 0);
    chk("tmo_busy", busy_o, 1);
    tick();
    chk("tmo_wb_vld", wb_vld_o, 1);
    chk("tmo_wb_err", wb_err_o, 1);
    wb_rdy_i = 1'b1;
    tick();
    wb_rdy_i = 1'b0;
    chk("tmo_idle", req_rdy_o, 1);
    chk("tmo_no_launch", 64'(n_launch - l0), 0);
    chk("tmo_no_stb", 64'(n_stbwr - s0), 0);

    // Flush in WAIT_DATA then a late return
    l0 = n_launch;
    accept(c_AMO_XOR, c_DWORD, 40'h5000, 2'd2);
    dc_rd_gnt_i = 1'b1;
    tick();
    dc_rd_gnt_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_wd_idle", req_rdy_o, 1);
    chk("flush_wd_busy", busy_o, 0);
    tick();
    dc_rd_data_vld_i = 1'b1; dc_rd_data_i = 64'h55;
    tick();
    dc_rd_data_vld_i = 1'b0;
    chk("late_data_idle", busy_o, 0);
    chk("late_data_no_wb", wb_vld_o, 0);
    tick();
    chk("late_data_no_launch", 64'(n_launch - l0), 0);

    // Flush in RD_REQ
    accept(c_AMO_AND, c_WORD, 40'h6000, 2'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_rr_idle", req_rdy_o, 1);
    chk("flush_rr_rd_req", dc_rd_req_o, 0);

    // Same-cycle flush and request in IDLE
    req_vld_i = 1'b1; flush_i = 1'b1;
    tick();
    req_vld_i = 1'b0; flush_i = 1'b0;
    chk("flush_acc_idle", req_rdy_o, 1);
    chk("flush_acc_rd_req", dc_rd_req_o, 0);

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      sz  = ($urandom_range(0, 1) == 1) ? c_DWORD : c_WORD;
      a   = PA_WIDTH'({$urandom, $urandom});
      a[2:0] = 3'b000;
      if (sz == c_WORD) a[2] = 1'($urandom_range(0, 1));
      mem = {$urandom, $urandom};
      rs2 = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) mem = 64'($urandom_range(0, 9)) << (32 * $urandom_range(0, 1));
      run_amo(funcs[$urandom_range(0, 8)], sz, a, 2'($urandom_range(0, 3)), mem, rs2,
              $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
              $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aq_lsu_amo_ctrl.md
Name: aq_lsu_amo_ctrl

Overview:
Sequencer for the LSU AMO ALU. It accepts one AMO request at a time from the LSU pipeline and issues the read of the memory operand to the dcache. It then drives the ALU operands and captures the registered ALU result. Finally it writes the new value into the owning store-buffer entry and returns the old memory value to the register-file writeback path.

Parameters:
PA_WIDTH, 40, physical address width.
TMO_W, 8, width of the read-data timeout counter. A timeout fires after 2^TMO_W-1 cycles in WAIT_DATA.

Ports:
amo_clk  in  1  clock
cpurst_b  in  1  reset, asynchronous, active-low
req_vld  in  1  AMO request valid
req_rdy  out  1  controller can accept a request (state IDLE)
req_func  in  5  AMO op code, ALU func encoding
req_size  in  2  2'b10 word, 2'b11 dword
req_addr  in  PA_WIDTH  operand address, naturally aligned
req_stb_id  in  2  store-buffer entry holding rs2 / receiving the result
flush  in  1  pipeline kill
dc_rd_req  out  1  dcache read request
dc_rd_gnt  in  1  dcache accepts the read
dc_rd_addr  out  PA_WIDTH  read address (latched req_addr)
dc_rd_data_vld  in  1  read data return
dc_rd_data  in  64  read data, doubleword aligned
dc_rd_err  in  1  bus/access error, qualified by dc_rd_data_vld
alu_src_vld  out  1  one-cycle ALU launch
alu_func  out  5  latched func
alu_size  out  2  latched size
alu_src0  out  64  formatted memory operand
alu_stb_id  out  2  latched stb id
alu_rst_vld  in  1  ALU result valid
alu_rst  in  64  ALU result
alu_rst_stb_id  in  2  ALU result id
stb_wr_vld  out  1  store-buffer data write
stb_wr_rdy  in  1  store buffer accepts
stb_wr_id  out  2  target entry
stb_wr_data  out  64  new value, lane-aligned
stb_wr_be  out  8  byte enables
wb_vld  out  1  old-value writeback valid
wb_rdy  in  1  writeback accepted
wb_data  out  64  old value; word ops sign-extended from bit 31
wb_err  out  1  access error, no store performed
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. All outputs deassert to 0, except req_rdy, which resets to 1. Latched fields and the counter reset to 0.
- Request accept: req_vld && req_rdy latches func, size, addr and stb_id, then moves to RD_REQ. Requests are not accepted in any other state.
- RD_REQ: dc_rd_req=1. On dc_rd_gnt, move to WAIT_DATA and clear the counter.
- WAIT_DATA: the counter increments each cycle. On dc_rd_data_vld:
  - If dc_rd_err, capture the error and move to RESP.
  - Otherwise capture the old value and move to LAUNCH.
  - A counter saturating at all-ones is treated as an error (same path).
- Operand formatting:
  - Word ops: alu_src0 = {32'b0, data[addr[2]*32 +: 32]}.
  - Dword ops: alu_src0 = data.
  - wb_data = the sign-extended word for word ops, or the full doubleword for dword ops.
- LAUNCH: alu_src_vld=1 for exactly one cycle, then move to WAIT_RST.
- WAIT_RST: the ALU result registers with 1-cycle latency. On alu_rst_vld with alu_rst_stb_id == latched id, latch the result and move to STORE. A mismatched id is ignored.
- STORE: stb_wr_vld held until stb_wr_rdy, then move to RESP.
  - Word ops: stb_wr_data = {rst[31:0], rst[31:0]}, stb_wr_be = addr[2] ? 8'hF0 : 8'h0F.
  - Dword ops: stb_wr_data = rst, stb_wr_be = 8'hFF.
- RESP: wb_vld held until wb_rdy; wb_err reflects the captured error. Then move to IDLE.
- Flush:
  - In RD_REQ or WAIT_DATA, return to IDLE immediately. No wb and no stb write.
  - A read return arriving after the flush is dropped.
  - Flush in LAUNCH/WAIT_RST/STORE/RESP is ignored; the memory update is committed.
- Same-cycle flush and accept in IDLE: the request is not accepted.
- Error path never raises alu_src_vld or stb_wr_vld.
- Latency with no backpressure: accept to wb_vld = 5 cycles plus dcache latency.

Decomposition:
- Shared package: state encoding, size constants WORD/DWORD, and AMO func codes (add 00000, swap 00001, xor 00100, or 01000, and 01100, min 10000, max 10100, minu 11000, maxu 11100).
- Sub-module aq_lsu_amo_fmt (combinational): lane select, zero/sign extension, byte-enable and write-data replication.

Test Plan:
- amoadd.d at addr 0x1000: mem=0x5, rs2=0x3 → stb_wr_data=0x8, be=FF; wb_data=0x5, wb_err=0.
- amomaxu.w at addr 0x1004: mem dword 0xFFFFFFFF_00000000, rs2=1 → alu_src0=0x00000000_FFFFFFFF; stb_wr_data=0xFFFFFFFF_FFFFFFFF, be=F0; wb_data=0xFFFFFFFF_FFFFFFFF.
- dc_rd_err=1 on return → wb_vld with wb_err=1; alu_src_vld and stb_wr_vld never asserted.
- No data return for 255 cycles (TMO_W=8) → timeout error response on cycle 255.
- Flush in WAIT_DATA followed by a late data return → back to IDLE and the data is ignored. Flush in STORE → store completes and wb is delivered.
- stb_wr_rdy held low 10 cycles and wb_rdy low 3 cycles → outputs stable, req_rdy=0 throughout. Back-to-back requests are accepted only after wb handshake.
